// File: rtl/parity_frame_tx_pkg.sv
// Shared types and framing constants for the parity frame transmitter.
package parity_frame_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int   FRAME_DATA_BITS = 9;
  localparam logic START_BIT       = 1'b0;
  localparam logic STOP_BIT        = 1'b1;

endpackage

// File: rtl/parity_frame_tx_check.sv
// Combinational parity re-check of a 9-bit {parity, data} word; check=1 flags an error.
module parity_check9 (
  input  logic [8:0] word,
  input  logic       odd_mode,
  output logic       check
);

  assign check = (^word) ^ odd_mode;

endmodule

// File: rtl/parity_frame_tx.sv
// Accepts a parity-encoded word, re-checks its parity and serialises it as
// start bit, 9 bits LSB first, stop bit, with CLKS_PER_BIT clocks per bit.
module parity_frame_tx
  import parity_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8:0]           in_word,
  input  logic                 parity_control,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 frame_done,
  output logic                 parity_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BIT  = 4'(FRAME_DATA_BITS - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  state_t               state_q, state_d;
  logic [7:0]           baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [8:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 perr_q, perr_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 check;
  logic                 baud_wrap;

  parity_check9 u_check (
    .word     (in_word),
    .odd_mode (parity_control),
    .check    (check)
  );

  assign baud_wrap  = (baud_q == BAUD_LAST);
  assign in_ready   = (state_q == IDLE);
  assign tx_busy    = (state_q != IDLE);
  assign frame_done = (state_q == STOP) && baud_wrap;
  assign tx_out     = tx_q;
  assign parity_err = perr_q;
  assign err_count  = cnt_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    perr_d  = perr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        tx_d = STOP_BIT;
        if (in_valid) begin
          state_d = START;
          baud_d  = 8'd0;
          bit_d   = 4'd0;
          shift_d = in_word;
          tx_d    = START_BIT;
          perr_d  = check;
          if (check && (cnt_q != CNT_MAX)) cnt_d = cnt_q + ERR_CNT_W'(1);
        end
      end
      START: begin
        if (baud_wrap) begin
          state_d = DATA;
          baud_d  = 8'd0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_d = 8'd0;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
            tx_d    = STOP_BIT;
          end else begin
            // tx is registered, so load the bit that becomes current after the shift
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          state_d = IDLE;
          baud_d  = 8'd0;
        end else begin
          baud_d = baud_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= 8'd0;
      bit_q   <= 4'd0;
      shift_q <= 9'd0;
      tx_q    <= STOP_BIT;
      perr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      perr_q  <= perr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed and randomized bench for parity_frame_tx against a frame-level reference model.
module tb_parity_frame_tx;

  localparam int CPB   = 4;
  localparam int CNT_W = 2;
  localparam int FRAME = 11 * CPB;

  logic             clk = 1'b0;
  logic             reset;
  logic [8:0]       in_word;
  logic             parity_control;
  logic             in_valid;
  logic             in_ready;
  logic             tx_out;
  logic             tx_busy;
  logic             frame_done;
  logic             parity_err;
  logic [CNT_W-1:0] err_count;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int exp_cnt   = 0;

  parity_frame_tx #(.CLKS_PER_BIT(CPB), .ERR_CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_word        (in_word),
    .parity_control (parity_control),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .tx_out         (tx_out),
    .tx_busy        (tx_busy),
    .frame_done     (frame_done),
    .parity_err     (parity_err),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [8:0] w, input logic mode);
    return logic'(($countones(w) % 2) != int'(mode));
  endfunction

  // Step one clock and land at the sampling point 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("wait_idle", {31'd0, in_ready}, 32'd1);
  endtask

  // Entered just after the accepting edge; walks the whole frame, ends just after its last edge.
  task automatic check_frame(input logic [8:0] w, input bit scramble);
    logic line [11];
    line[0] = 1'b0;
    for (int i = 0; i < 9; i++) line[i+1] = w[i];
    line[10] = 1'b1;
    for (int k = 1; k <= FRAME; k++) begin
      chk($sformatf("tx_out c%0d", k), {31'd0, tx_out}, {31'd0, line[(k-1)/CPB]});
      chk($sformatf("frame_done c%0d", k), {31'd0, frame_done}, {31'd0, k == FRAME});
      chk($sformatf("busy c%0d", k), {31'd0, tx_busy}, 32'd1);
      chk($sformatf("in_ready c%0d", k), {31'd0, in_ready}, 32'd0);
      if (scramble) begin
        in_word        = 9'($urandom);
        parity_control = 1'($urandom);
      end
      tick();
    end
    chk("post in_ready", {31'd0, in_ready}, 32'd1);
    chk("post tx_out", {31'd0, tx_out}, 32'd1);
    chk("post busy", {31'd0, tx_busy}, 32'd0);
  endtask

  task automatic accept(input logic [8:0] w, input logic mode);
    logic e;
    wait_idle();
    in_word        = w;
    parity_control = mode;
    in_valid       = 1'b1;
    tick();
    in_valid = 1'b0;
    e = model_err(w, mode);
    if (e && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    chk("parity_err", {31'd0, parity_err}, {31'd0, e});
    chk("err_count", {30'd0, err_count}, exp_cnt);
  endtask

  initial begin
    reset          = 1'b1;
    in_valid       = 1'b1;
    in_word        = 9'h134;
    parity_control = 1'b0;

    // Reset hold with a pending word
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst tx_out", {31'd0, tx_out}, 32'd1);
      chk("rst in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst err_count", {30'd0, err_count}, 32'd0);
      chk("rst busy", {31'd0, tx_busy}, 32'd0);
      chk("rst parity_err", {31'd0, parity_err}, 32'd0);
      chk("rst frame_done", {31'd0, frame_done}, 32'd0);
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    tick();
    chk("idle tx_out", {31'd0, tx_out}, 32'd1);

    // Good even frame, upstream scrambled mid-frame
    accept(9'h134, 1'b0);
    check_frame(9'h134, 1'b1);

    // Odd-mode error, frame still sent unchanged
    accept(9'h134, 1'b1);
    check_frame(9'h134, 1'b1);

    // Back-to-back with in_valid held
    wait_idle();
    in_word        = 9'h134;
    parity_control = 1'b0;
    in_valid       = 1'b1;
    tick();
    in_word = 9'h0FF;
    chk("b2b first busy", {31'd0, tx_busy}, 32'd1);
    check_frame(9'h134, 1'b0);
    tick();
    in_valid = 1'b0;
    if (model_err(9'h0FF, 1'b0) && exp_cnt < 3) exp_cnt++;
    chk("b2b second accepted", {31'd0, tx_busy}, 32'd1);
    chk("b2b parity_err", {31'd0, parity_err}, {31'd0, model_err(9'h0FF, 1'b0)});
    chk("b2b err_count", {30'd0, err_count}, exp_cnt);
    check_frame(9'h0FF, 1'b0);

    // Randomized words and modes
    for (int r = 0; r < 8; r++) begin
      logic [8:0] w;
      logic       m;
      w = 9'($urandom);
      m = 1'($urandom);
      accept(w, m);
      check_frame(w, 1'b1);
    end

    // Mid-frame reset during data bit 4, after a bad word
    accept(9'h001, 1'b0);
    for (int k = 1; k < 5 + 4 * CPB + 1; k++) tick();
    chk("mid tx_out is bit4", {31'd0, tx_out}, 32'd0);
    chk("mid busy", {31'd0, tx_busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    exp_cnt = 0;
    chk("mid rst tx_out", {31'd0, tx_out}, 32'd1);
    chk("mid rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid rst busy", {31'd0, tx_busy}, 32'd0);
    chk("mid rst parity_err", {31'd0, parity_err}, 32'd0);
    chk("mid rst err_count", {30'd0, err_count}, 32'd0);

    // Saturation of the 2-bit error counter
    for (int s = 0; s < 5; s++) begin
      logic [8:0] w;
      w = 9'($urandom);
      if (!model_err(w, 1'b0)) w[8] = ~w[8];
      accept(w, 1'b0);
      chk("sat count", {30'd0, err_count}, (s < 3) ? s + 1 : 3);
      check_frame(w, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
